// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: operand/result valid-ready bundle (in_valid/in_ready/a/b/borrow_in in, out_valid/out_ready/diff/borrow_out/ovf/zero out)
interface nibble_serial_subtractor_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  logic             zero;
  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: diff = a - b - borrow_in, SLICE bits per clock with registered borrow; ports clk, rst_n (sync, active-low), bus (slave: operands in, result out)
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, diff_r, diff_nx;
  logic [SLICE:0]   sub;
  logic [CW-1:0]    cnt;
  logic             borrow, borrow_out, ovf, zero, last;
  assign last    = cnt == CW'(N - 1);
  assign sub     = {1'b0, a_r[SLICE-1:0]} - {1'b0, b_r[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
  assign diff_nx = WIDTH'({sub[SLICE-1:0], diff_r} >> SLICE);
  always_comb begin
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               state == DONE ? (bus.out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      borrow     <= 1'b0;
      diff_r     <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        a_r    <= bus.a;
        b_r    <= bus.b;
        borrow <= bus.borrow_in;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_r    <= a_r >> SLICE;
        b_r    <= b_r >> SLICE;
        diff_r <= diff_nx;
        borrow <= sub[SLICE];
        cnt    <= cnt + 1'b1;
        if (last) begin
          borrow_out <= sub[SLICE];
          zero       <= diff_nx == '0;
          ovf        <= (a_r[SLICE-1] != b_r[SLICE-1]) && (sub[SLICE-1] != a_r[SLICE-1]);
        end
      end
    end
  end
  assign bus.in_ready   = state == IDLE;
  assign bus.out_valid  = state == DONE;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out;
  assign bus.ovf        = ovf;
  assign bus.zero       = zero;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed-vector self-checking bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  nibble_serial_subtractor_if #(.WIDTH(16)) bus();
  nibble_serial_subtractor #(.WIDTH(16), .SLICE(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic bi);
    @(negedge clk);
    check("accept_rdy", 32'(bus.in_ready), 1);
    bus.a = a;
    bus.b = b;
    bus.borrow_in = bi;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    int lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
      check("run_rdy", 32'(bus.in_ready), 0);
    end
    check("latency", 32'(lat), 4);
  endtask
  task automatic check_res(input logic [15:0] d, input logic bo, input logic ov, input logic z);
    check("out_valid", 32'(bus.out_valid), 1);
    check("diff", 32'(bus.diff), 32'(d));
    check("borrow_out", 32'(bus.borrow_out), 32'(bo));
    check("ovf", 32'(bus.ovf), 32'(ov));
    check("zero", 32'(bus.zero), 32'(z));
  endtask
  task automatic finish_op();
    @(negedge clk);
    check("done_rdy", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", 32'(bus.out_valid), 0);
    check("drain_rdy", 32'(bus.in_ready), 1);
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input logic [15:0] d, input logic bo, input logic ov, input logic z);
    start(a, b, bi);
    wait_valid();
    check_res(d, bo, ov, z);
    finish_op();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_diff", 32'(bus.diff), 0);
    check("rst_bo", 32'(bus.borrow_out), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_zero", 32'(bus.zero), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", 32'(bus.in_ready), 1);
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op(16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op(16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op(16'h0001, 16'h8000, 1'b0, 16'h8001, 1'b1, 1'b1, 1'b0);
    run_op(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
    start(16'h5555, 16'h1111, 1'b0);
    bus.a = 16'hFFFF;
    bus.b = 16'h0000;
    bus.borrow_in = 1'b1;
    bus.in_valid = 1'b1;
    wait_valid();
    repeat (3) begin
      check_res(16'h4444, 1'b0, 1'b0, 1'b0);
      check("bp_rdy", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check_res(16'h4444, 1'b0, 1'b0, 1'b0);
    check("bp_rdy", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_drain_valid", 32'(bus.out_valid), 0);
    check("bp_drain_rdy", 32'(bus.in_ready), 1);
    run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
    start(16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_rdy", 32'(bus.in_ready), 1);
    repeat (6) begin
      check("abort_valid", 32'(bus.out_valid), 0);
      @(negedge clk);
    end
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
